slc3_sequencer: RTL and testbench
=================================

// Module: slc3_sequencer
// PURPOSE
//  Parametrised SLC-3 instruction sequencer (ISDU). Fetches, decodes and executes
//  ADD/AND/NOT/LDR/STR/BR/JMP/JSR/PSE. Drives all datapath load, gate, mux, ALU and
//  memory controls of the cpu block. Memory wait states come from a counter, or
//  optionally from a ready handshake, instead of hard-coded wait states.
// PARAMETERS
//  MEM_WAIT   3  cycles mem_ena is held per access when USE_READY=0 (legal 1..15)
//  USE_READY  0  1: memory accesses end on mem_rdy; MEM_WAIT is ignored
//  PAUSE_EN   1  1: PSE (ir[15:12]=4'b1101) enters PAUSE1/PAUSE2; 0: PSE acts as NOP
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, synchronous, active-high
//  ir          in   16  instruction register contents
//  ben         in   1   branch enable (registered in datapath)
//  run_i       in   1   start from HALTED
//  continue_i  in   1   pause release (level, debounced upstream)
//  mem_rdy     in   1   memory access complete (used only when USE_READY=1)
//  ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_ben, ld_reg, ld_cc  out 1 each: register loads
//  gate_pc, gate_mdr, gate_alu, gate_marmux  out 1 each: bus drivers, at most one high
//  pcmux       out  2   00 PC+1, 01 bus, 10 address adder
//  addr1_sel   out  1   0 PC, 1 SR1
//  addr2_sel   out  2   00 zero, 01 sext[5:0], 10 sext[8:0], 11 sext[10:0]
//  sr1_sel     out  1   1 ir[8:6], 0 ir[11:9]
//  dr_sel      out  1   0 ir[11:9], 1 R7
//  sr2_sel     out  1   0 SR2 register, 1 sext[4:0]
//  aluk        out  2   00 ADD, 01 AND, 10 NOT, 11 PASSA
//  mem_ena, mem_wr_ena, mio_en  out 1 each: memory enable, write, MDR source (1 = memory)
//  halted_o    out  1   high in HALTED
// BEHAVIOUR
//  - Moore outputs decoded from state. Every output is 0 in HALTED, except halted_o=1.
//  - Reset at any edge, including mid-access: state becomes HALTED, wait counter 0,
//    no write completes after that edge.
//  - HALTED -> S18 when run_i=1. run_i is ignored in all other states.
//  - S18: gate_pc, ld_mar, ld_pc, pcmux=00.
//  - S33 (fetch wait): mem_ena=1, mio_en=1; counter wcnt counts up from 0.
//    - Exit: USE_READY=0 when wcnt==MEM_WAIT-1; USE_READY=1 on the first cycle mem_rdy=1.
//    - ld_mdr=1 only in the exit cycle. wcnt clears on exit.
//    - Next state: S35.
//  - S35: gate_mdr, ld_ir -> S32.
//  - S32: ld_ben. Decode ir[15:12]:
//    - 0001 -> S1, 0101 -> S5, 1001 -> S9, 0110 -> S6, 0111 -> S7, 0100 -> S4,
//      1100 -> S12, 0000 -> S0, 1101 -> PAUSE1 (or S18 when PAUSE_EN=0).
//    - Any other opcode -> S18.
//  - S1/S5/S9: sr1_sel=1, dr_sel=0, sr2_sel=ir[5], aluk=00/01/10, gate_alu, ld_reg, ld_cc -> S18.
//  - LDR:
//    - S6: sr1_sel=1, addr1=1, addr2=01, gate_marmux, ld_mar -> S25.
//    - S25: read wait, identical to S33 -> S27.
//    - S27: gate_mdr, dr_sel=0, ld_reg, ld_cc -> S18.
//  - STR:
//    - S7: same controls as S6 -> S23.
//    - S23: sr1_sel=0, aluk=11, gate_alu, mio_en=0, ld_mdr -> S16.
//    - S16: mem_ena=1, mem_wr_ena=1 for the full wait, same exit rule as S33, no ld_mdr -> S18.
//  - JSR:
//    - S4: dr_sel=1, gate_pc, ld_reg -> S21.
//    - S21: addr1=0, addr2=11, pcmux=10, ld_pc -> S18.
//  - JMP: S12: sr1_sel=1, addr1=1, addr2=00, pcmux=10, ld_pc -> S18.
//  - BR:
//    - S0: no outputs -> S22 if ben=1, else S18.
//    - S22: addr1=0, addr2=10, pcmux=10, ld_pc -> S18.
//  - PAUSE1: ld_led. Goes to PAUSE2 when continue_i=1.
//  - PAUSE2: ld_led. Goes to S18 when continue_i=0.
//  - USE_READY=1 with mem_rdy stuck low: the FSM waits indefinitely in the wait state.
//  - mem_rdy outside a wait state is ignored.
//  - wcnt is wide enough to hold MEM_WAIT-1 and never wraps.
// TESTING
//  - Reset, run_i=1 one cycle, MEM_WAIT=3: S18,S33x3,S35,S32; ld_mdr high on 3rd S33 only.
//  - ir=16'h1242 (ADD R1,R1,R2): S1 with sr2_sel=0, aluk=00, ld_reg=1, ld_cc=1, then S18.
//  - ir=16'h7283 (STR R1,R2,#3): S7,S23,S16 with mem_wr_ena=1 for exactly MEM_WAIT cycles.
//  - ir=16'h0E05 (BRnzp +5): ben=1 -> S0,S22 with pcmux=10, addr2=10; ben=0 -> S0,S18.
//  - USE_READY=1, LDR: mem_rdy low 5 cycles then high 1 -> 6 S25 cycles, ld_mdr only in last.
//  - reset in 2nd cycle of S16 -> next state HALTED, all outputs 0, mem_wr_ena low.

Source files
------------

// File: rtl/slc3_sequencer.sv
// ----------------------------------------------------------------------------
// slc3_sequencer
//   Instruction sequencer (ISDU) for the SLC-3 cpu. Walks each instruction
//   through fetch, decode and execute, and drives every datapath load, bus
//   gate, mux select, ALU and memory control.
//   ADD/AND/NOT/LDR/STR/BR/JMP/JSR/PSE are executed. Any other opcode returns
//   to fetch.
//   Each memory access holds mem_ena for a fixed MEM_WAIT cycles. When
//   USE_READY=1, the access instead lasts until mem_rdy is seen.
//
// Parameters
//   MEM_WAIT   cycles per memory access when USE_READY=0 (1..15)
//   USE_READY  1: accesses end on mem_rdy; MEM_WAIT is ignored
//   PAUSE_EN   1: PSE pauses (PAUSE1/PAUSE2); 0: PSE is a NOP
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   ir[15:0]          instruction register contents
//   ben               branch enable from the datapath
//   run_i             leaves HALTED
//   continue_i        pause release (level)
//   mem_rdy           memory access complete (USE_READY=1 only)
//   ld_*              register load strobes
//   gate_*            bus drivers, at most one high
//   pcmux, addr1_sel, addr2_sel, sr1_sel, dr_sel, sr2_sel, aluk
//                     datapath mux and ALU selects
//   mem_ena, mem_wr_ena, mio_en
//                     memory enable, memory write, MDR source
//                     (mio_en=1 selects memory)
//   halted_o          high while HALTED
// ----------------------------------------------------------------------------
module slc3_sequencer #(
   parameter int MEM_WAIT  = 3,
   parameter bit USE_READY = 1'b0,
   parameter bit PAUSE_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic        ben,
   input  logic        run_i,
   input  logic        continue_i,
   input  logic        mem_rdy,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        ld_ir,
   output logic        ld_pc,
   output logic        ld_led,
   output logic        ld_ben,
   output logic        ld_reg,
   output logic        ld_cc,
   output logic        gate_pc,
   output logic        gate_mdr,
   output logic        gate_alu,
   output logic        gate_marmux,
   output logic [1:0]  pcmux,
   output logic        addr1_sel,
   output logic [1:0]  addr2_sel,
   output logic        sr1_sel,
   output logic        dr_sel,
   output logic        sr2_sel,
   output logic [1:0]  aluk,
   output logic        mem_ena,
   output logic        mem_wr_ena,
   output logic        mio_en,
   output logic        halted_o
);

   // Just wide enough to hold MEM_WAIT-1, so the counter can never wrap.
   localparam int                WCNT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_WAIT - 1);

   typedef enum logic [4:0] {
      HALTED, S18, S33, S35, S32,
      S1, S5, S9,
      S6, S25, S27,
      S7, S23, S16,
      S4, S21, S12,
      S0, S22,
      PAUSE1, PAUSE2
   } state_e;

   state_e            state, next_state;
   logic [WCNT_W-1:0] wcnt;
   logic              in_wait;
   logic              mem_done;

   // The decoder only looks at the opcode and ir[5]. The other fields go to
   // the datapath directly.
   logic unused_ir;
   assign unused_ir = ^{ir[11:6], ir[4:0]};

   // S33 (fetch) and S25 (LDR) are read waits. S16 (STR) is the write wait.
   assign in_wait  = (state == S33) || (state == S25) || (state == S16);
   assign mem_done = USE_READY ? mem_rdy : (wcnt == WCNT_LAST);

   // State register and wait counter. The counter runs only inside a counted
   // wait and clears on the exit cycle. In ready mode it stays at zero.
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HALTED;
         wcnt  <= '0;
      end else begin
         state <= next_state;
         if (in_wait && !USE_READY && !mem_done)
            wcnt <= wcnt + 1'b1;
         else
            wcnt <= '0;
      end
   end

   // Next-state logic
   // NOTE: next_state takes a default before the case, so no path through
   // this block can leave it unassigned and infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         HALTED:  if (run_i) next_state = S18;
         S18:     next_state = S33;
         S33:     if (mem_done) next_state = S35;
         S35:     next_state = S32;
         S32: begin
            case (ir[15:12])
               4'b0001: next_state = S1;
               4'b0101: next_state = S5;
               4'b1001: next_state = S9;
               4'b0110: next_state = S6;
               4'b0111: next_state = S7;
               4'b0100: next_state = S4;
               4'b1100: next_state = S12;
               4'b0000: next_state = S0;
               4'b1101: next_state = PAUSE_EN ? PAUSE1 : S18;
               default: next_state = S18;
            endcase
         end
         S1, S5, S9: next_state = S18;
         S6:      next_state = S25;
         S25:     if (mem_done) next_state = S27;
         S27:     next_state = S18;
         S7:      next_state = S23;
         S23:     next_state = S16;
         S16:     if (mem_done) next_state = S18;
         S4:      next_state = S21;
         S21:     next_state = S18;
         S12:     next_state = S18;
         S0:      next_state = ben ? S22 : S18;
         S22:     next_state = S18;
         PAUSE1:  if (continue_i) next_state = PAUSE2;
         PAUSE2:  if (!continue_i) next_state = S18;
         default: next_state = HALTED;
      endcase
   end

   // Output decode. Outputs depend only on the state, except ld_mdr during a
   // read wait: it marks the exit cycle, so MDR captures the final memory
   // data.
   always_comb begin
      ld_mar      = 1'b0;
      ld_mdr      = 1'b0;
      ld_ir       = 1'b0;
      ld_pc       = 1'b0;
      ld_led      = 1'b0;
      ld_ben      = 1'b0;
      ld_reg      = 1'b0;
      ld_cc       = 1'b0;
      gate_pc     = 1'b0;
      gate_mdr    = 1'b0;
      gate_alu    = 1'b0;
      gate_marmux = 1'b0;
      pcmux       = 2'b00;
      addr1_sel   = 1'b0;
      addr2_sel   = 2'b00;
      sr1_sel     = 1'b0;
      dr_sel      = 1'b0;
      sr2_sel     = 1'b0;
      aluk        = 2'b00;
      mem_ena     = 1'b0;
      mem_wr_ena  = 1'b0;
      mio_en      = 1'b0;
      halted_o    = 1'b0;
      unique case (state)
         HALTED: halted_o = 1'b1;
         S18: begin
            gate_pc = 1'b1;
            ld_mar  = 1'b1;
            ld_pc   = 1'b1;
         end
         S33, S25: begin
            mem_ena = 1'b1;
            mio_en  = 1'b1;
            ld_mdr  = mem_done;
         end
         S35: begin
            gate_mdr = 1'b1;
            ld_ir    = 1'b1;
         end
         S32: ld_ben = 1'b1;
         S1, S5, S9: begin
            sr1_sel  = 1'b1;
            sr2_sel  = ir[5];
            aluk     = (state == S1) ? 2'b00 : (state == S5) ? 2'b01 : 2'b10;
            gate_alu = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
         end
         // LDR/STR effective address: base register + sext(offset6) into MAR.
         S6, S7: begin
            sr1_sel     = 1'b1;
            addr1_sel   = 1'b1;
            addr2_sel   = 2'b01;
            gate_marmux = 1'b1;
            ld_mar      = 1'b1;
         end
         S27: begin
            gate_mdr = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
         end
         // STR source register ir[11:9] passes through the ALU into MDR.
         S23: begin
            aluk     = 2'b11;
            gate_alu = 1'b1;
            ld_mdr   = 1'b1;
         end
         S16: begin
            mem_ena    = 1'b1;
            mem_wr_ena = 1'b1;
         end
         S4: begin
            dr_sel  = 1'b1;
            gate_pc = 1'b1;
            ld_reg  = 1'b1;
         end
         S21: begin
            addr2_sel = 2'b11;
            pcmux     = 2'b10;
            ld_pc     = 1'b1;
         end
         S12: begin
            sr1_sel   = 1'b1;
            addr1_sel = 1'b1;
            pcmux     = 2'b10;
            ld_pc     = 1'b1;
         end
         S0: ;
         S22: begin
            addr2_sel = 2'b10;
            pcmux     = 2'b10;
            ld_pc     = 1'b1;
         end
         PAUSE1, PAUSE2: ld_led = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_slc3_sequencer.sv
// ----------------------------------------------------------------------------
// tb_slc3_sequencer
//   Two sequencers run side by side: g_dut[0] counts a fixed MEM_WAIT per
//   access, and g_dut[1] uses the mem_rdy handshake. Only the selected one
//   runs; the other is held in reset.
//   Expected control words come from a per-phase table of the instruction
//   flow. Each instruction is walked cycle by cycle in procedural form.
// ----------------------------------------------------------------------------
module tb_slc3_sequencer;

   localparam int MEM_WAIT = 3;

   typedef struct packed {
      logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_ben, ld_reg, ld_cc;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux;
      logic       addr1_sel;
      logic [1:0] addr2_sel;
      logic       sr1_sel, dr_sel, sr2_sel;
      logic [1:0] aluk;
      logic       mem_ena, mem_wr_ena, mio_en, halted_o;
   } ctl_t;

   typedef enum {
      P_HALT, P_FETCH, P_RD_WAIT, P_RD_LAST, P_WR_WAIT, P_S35, P_DEC,
      P_ADD, P_AND, P_NOT, P_EA, P_S27, P_S23, P_S4, P_S21, P_S12,
      P_S0, P_S22, P_PAUSE
   } phase_e;

   typedef struct {
      logic [15:0] ir;
      logic        ben;
      int          n;
      ctl_t        exp [6];
   } vec_t;

   logic        clk = 1'b0;
   logic [1:0]  rst_v = 2'b11;
   logic [15:0] ir = '0;
   logic        ben = 1'b0, run_i = 1'b0, continue_i = 1'b0, mem_rdy = 1'b0;
   ctl_t [1:0]  outs;

   int sel         = 0;
   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_ben, ld_reg, ld_cc;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2_sel, aluk;
      logic       addr1_sel, sr1_sel, dr_sel, sr2_sel;
      logic       mem_ena, mem_wr_ena, mio_en, halted_o;

      slc3_sequencer #(
         .MEM_WAIT (MEM_WAIT),
         .USE_READY(g == 1),
         .PAUSE_EN (1'b1)
      ) u_dut (
         .clk        (clk),
         .reset      (rst_v[g]),
         .ir         (ir),
         .ben        (ben),
         .run_i      (run_i),
         .continue_i (continue_i),
         .mem_rdy    (mem_rdy),
         .ld_mar     (ld_mar),
         .ld_mdr     (ld_mdr),
         .ld_ir      (ld_ir),
         .ld_pc      (ld_pc),
         .ld_led     (ld_led),
         .ld_ben     (ld_ben),
         .ld_reg     (ld_reg),
         .ld_cc      (ld_cc),
         .gate_pc    (gate_pc),
         .gate_mdr   (gate_mdr),
         .gate_alu   (gate_alu),
         .gate_marmux(gate_marmux),
         .pcmux      (pcmux),
         .addr1_sel  (addr1_sel),
         .addr2_sel  (addr2_sel),
         .sr1_sel    (sr1_sel),
         .dr_sel     (dr_sel),
         .sr2_sel    (sr2_sel),
         .aluk       (aluk),
         .mem_ena    (mem_ena),
         .mem_wr_ena (mem_wr_ena),
         .mio_en     (mio_en),
         .halted_o   (halted_o)
      );

      assign outs[g] = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_ben, ld_reg, ld_cc,
                        gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr1_sel,
                        addr2_sel, sr1_sel, dr_sel, sr2_sel, aluk,
                        mem_ena, mem_wr_ena, mio_en, halted_o};
   end

   // Control word required in each phase of the instruction flow.
   function automatic ctl_t ctl(input phase_e p, input logic ir5);
      ctl_t c;
      c = '0;
      case (p)
         P_HALT:    c.halted_o = 1'b1;
         P_FETCH:   begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
         P_RD_WAIT: begin c.mem_ena = 1'b1; c.mio_en = 1'b1; end
         P_RD_LAST: begin c.mem_ena = 1'b1; c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
         P_WR_WAIT: begin c.mem_ena = 1'b1; c.mem_wr_ena = 1'b1; end
         P_S35:     begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
         P_DEC:     c.ld_ben = 1'b1;
         P_ADD, P_AND, P_NOT: begin
            c.sr1_sel  = 1'b1;
            c.sr2_sel  = ir5;
            c.aluk     = (p == P_ADD) ? 2'b00 : (p == P_AND) ? 2'b01 : 2'b10;
            c.gate_alu = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         P_EA: begin
            c.sr1_sel = 1'b1; c.addr1_sel = 1'b1; c.addr2_sel = 2'b01;
            c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
         end
         P_S27:   begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
         P_S23:   begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
         P_S4:    begin c.dr_sel = 1'b1; c.gate_pc = 1'b1; c.ld_reg = 1'b1; end
         P_S21:   begin c.addr2_sel = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
         P_S12:   begin c.sr1_sel = 1'b1; c.addr1_sel = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
         P_S22:   begin c.addr2_sel = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
         P_PAUSE: c.ld_led = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Called one time unit after an edge, with this cycle's inputs driven.
   // Compares the selected DUT, moves one cycle on, and sets random values
   // on inputs that the next phase is expected to ignore.
   task automatic cyc(input string name, input ctl_t exp);
      #1;
      vectors++;
      if (outs[sel] !== exp) begin
         miscompares++;
         $display("FAIL %s: cfg=%0d got=%h expected=%h t=%0t", name, sel, outs[sel], exp, $time);
      end
      @(posedge clk);
      #1;
      run_i      = 1'($urandom);
      ben        = 1'($urandom);
      continue_i = 1'($urandom);
      mem_rdy    = 1'($urandom);
   endtask

   task automatic do_reset();
      rst_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      rst_v[sel] = 1'b0;
      run_i      = 1'b0;
   endtask

   // A memory access lasts MEM_WAIT cycles (cfg 0), or `low` not-ready
   // cycles plus one ready cycle (cfg 1).
   task automatic mem_access(input bit write, input int low);
      if (sel == 0) begin
         for (int i = 0; i < MEM_WAIT; i++)
            cyc(write ? "wr_wait" : "rd_wait",
                ctl(write ? P_WR_WAIT : ((i == MEM_WAIT - 1) ? P_RD_LAST : P_RD_WAIT), 1'b0));
      end else begin
         for (int i = 0; i < low; i++) begin
            mem_rdy = 1'b0;
            cyc(write ? "wr_wait" : "rd_wait", ctl(write ? P_WR_WAIT : P_RD_WAIT, 1'b0));
         end
         mem_rdy = 1'b1;
         cyc(write ? "wr_last" : "rd_last", ctl(write ? P_WR_WAIT : P_RD_LAST, 1'b0));
      end
   endtask

   task automatic fetch(input int low);
      cyc("S18", ctl(P_FETCH, 1'b0));
      mem_access(1'b0, low);
      cyc("S35", ctl(P_S35, 1'b0));
      cyc("S32", ctl(P_DEC, 1'b0));
   endtask

   // Execute phase of one instruction. Ends on the edge that returns to
   // fetch; the next fetch checks that S18.
   task automatic execute(input logic [15:0] iv, input logic bv, input int low);
      int n;
      case (iv[15:12])
         4'b0001: cyc("add", ctl(P_ADD, iv[5]));
         4'b0101: cyc("and", ctl(P_AND, iv[5]));
         4'b1001: cyc("not", ctl(P_NOT, iv[5]));
         4'b0110: begin
            cyc("ldr_ea", ctl(P_EA, 1'b0));
            mem_access(1'b0, low);
            cyc("ldr_s27", ctl(P_S27, 1'b0));
         end
         4'b0111: begin
            cyc("str_ea", ctl(P_EA, 1'b0));
            cyc("str_s23", ctl(P_S23, 1'b0));
            mem_access(1'b1, low);
         end
         4'b0100: begin
            cyc("jsr_s4", ctl(P_S4, 1'b0));
            cyc("jsr_s21", ctl(P_S21, 1'b0));
         end
         4'b1100: cyc("jmp", ctl(P_S12, 1'b0));
         4'b0000: begin
            ben = bv;
            cyc("br_s0", ctl(P_S0, 1'b0));
            if (bv) cyc("br_s22", ctl(P_S22, 1'b0));
         end
         4'b1101: begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
               continue_i = 1'b0;
               cyc("pause1_hold", ctl(P_PAUSE, 1'b0));
            end
            continue_i = 1'b1;
            cyc("pause1_rel", ctl(P_PAUSE, 1'b0));
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
               continue_i = 1'b1;
               cyc("pause2_hold", ctl(P_PAUSE, 1'b0));
            end
            continue_i = 1'b0;
            cyc("pause2_rel", ctl(P_PAUSE, 1'b0));
         end
         default: ;
      endcase
   endtask

   // Starts the selected DUT: reset, a few idle HALTED cycles, then run_i.
   task automatic start();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_i = 1'b0;
         cyc("halted_idle", ctl(P_HALT, 1'b0));
      end
      run_i = 1'b1;
      cyc("halted_run", ctl(P_HALT, 1'b0));
   endtask

   vec_t vt [10];

   initial begin
      logic [15:0] iv;

      // Directed execute sequences for MEM_WAIT=3 (counted mode).
      vt[0].ir = 16'h1242; vt[0].ben = 1'b0; vt[0].n = 1;
      vt[0].exp[0] = ctl(P_ADD, 1'b0);
      vt[1].ir = 16'h5A7F; vt[1].ben = 1'b0; vt[1].n = 1;
      vt[1].exp[0] = ctl(P_AND, 1'b1);
      vt[2].ir = 16'h927F; vt[2].ben = 1'b0; vt[2].n = 1;
      vt[2].exp[0] = ctl(P_NOT, 1'b1);
      vt[3].ir = 16'h7283; vt[3].ben = 1'b0; vt[3].n = 5;
      vt[3].exp[0] = ctl(P_EA, 1'b0);      vt[3].exp[1] = ctl(P_S23, 1'b0);
      vt[3].exp[2] = ctl(P_WR_WAIT, 1'b0); vt[3].exp[3] = ctl(P_WR_WAIT, 1'b0);
      vt[3].exp[4] = ctl(P_WR_WAIT, 1'b0);
      vt[4].ir = 16'h0E05; vt[4].ben = 1'b1; vt[4].n = 2;
      vt[4].exp[0] = ctl(P_S0, 1'b0);      vt[4].exp[1] = ctl(P_S22, 1'b0);
      vt[5].ir = 16'h0E05; vt[5].ben = 1'b0; vt[5].n = 1;
      vt[5].exp[0] = ctl(P_S0, 1'b0);
      vt[6].ir = 16'hC1C0; vt[6].ben = 1'b0; vt[6].n = 1;
      vt[6].exp[0] = ctl(P_S12, 1'b0);
      vt[7].ir = 16'h4805; vt[7].ben = 1'b0; vt[7].n = 2;
      vt[7].exp[0] = ctl(P_S4, 1'b0);      vt[7].exp[1] = ctl(P_S21, 1'b0);
      vt[8].ir = 16'h6283; vt[8].ben = 1'b0; vt[8].n = 5;
      vt[8].exp[0] = ctl(P_EA, 1'b0);      vt[8].exp[1] = ctl(P_RD_WAIT, 1'b0);
      vt[8].exp[2] = ctl(P_RD_WAIT, 1'b0); vt[8].exp[3] = ctl(P_RD_LAST, 1'b0);
      vt[8].exp[4] = ctl(P_S27, 1'b0);
      vt[9].ir = 16'hF025; vt[9].ben = 1'b0; vt[9].n = 0;

      @(posedge clk);
      #1;

      // ---------------- counted wait states ----------------
      sel = 0;
      start();
      for (int i = 0; i < 10; i++) begin
         ir = vt[i].ir;
         fetch(0);
         for (int j = 0; j < vt[i].n; j++) begin
            ben = vt[i].ben;
            cyc($sformatf("vec%0d_step%0d", i, j), vt[i].exp[j]);
         end
      end

      // Reset during the 2nd write-wait cycle: no further write strobe.
      ir = 16'h7283;
      fetch(0);
      cyc("str_ea", ctl(P_EA, 1'b0));
      cyc("str_s23", ctl(P_S23, 1'b0));
      cyc("s16_first", ctl(P_WR_WAIT, 1'b0));
      rst_v[0] = 1'b1;
      cyc("s16_second", ctl(P_WR_WAIT, 1'b0));
      rst_v[0] = 1'b0;
      run_i    = 1'b0;
      cyc("after_reset", ctl(P_HALT, 1'b0));
      run_i = 1'b0;
      cyc("after_reset_hold", ctl(P_HALT, 1'b0));

      run_i = 1'b1;
      cyc("restart", ctl(P_HALT, 1'b0));
      for (int k = 0; k < 150; k++) begin
         iv = 16'($urandom);
         iv[15:12] = 4'($urandom_range(0, 15));
         ir = iv;
         fetch(0);
         execute(iv, 1'($urandom), 0);
      end
      cyc("cfg0_end_s18", ctl(P_FETCH, 1'b0));

      // ---------------- ready handshake ----------------
      rst_v[0] = 1'b1;
      sel = 1;
      start();
      ir = 16'h6283;
      fetch(2);
      execute(16'h6283, 1'b0, 5);
      ir = 16'h7283;
      fetch(0);
      execute(16'h7283, 1'b0, 3);
      for (int k = 0; k < 150; k++) begin
         iv = 16'($urandom);
         iv[15:12] = 4'($urandom_range(0, 15));
         ir = iv;
         fetch($urandom_range(0, 4));
         execute(iv, 1'($urandom), $urandom_range(0, 4));
      end
      cyc("cfg1_end_s18", ctl(P_FETCH, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
